// File: rtl/mix_columns_seq.sv
// Time-shared AES MixColumns: mixes COLS_PER_CYCLE columns of a 128-bit state per clock.
// Define MIXCOL_INV_EN to build the InvMixColumns datapath, selected per state by in_inv.
module mix_columns_seq #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         out_inv,
   output logic         busy
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // With four columns per cycle the step wraps to 0 and the last group is group 0.
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

`ifdef MIXCOL_INV_EN
   function automatic logic [31:0] mix_inv(input logic [31:0] col);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int k = 0; k < 4; k++) begin
         a     = col[31-8*k -: 8];
         x2    = xtime(a);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[k] = x8 ^ a;
         mb[k] = x8 ^ x2 ^ a;
         md[k] = x8 ^ x4 ^ a;
         me[k] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   logic inv_q, inv_d;
`else
   logic unused_in_inv;
   assign unused_in_inv = in_inv;
`endif

   logic [1:0]   state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] work_q, work_d;
   logic [31:0]  col;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      col     = '0;
`ifdef MIXCOL_INV_EN
      inv_d   = inv_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d  = in_state;
               cnt_d   = '0;
               state_d = ST_BUSY;
`ifdef MIXCOL_INV_EN
               inv_d   = in_inv;
`endif
            end
         end
         ST_BUSY: begin
            for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
               col = work_q[127-32*(int'(cnt_q)+g) -: 32];
`ifdef MIXCOL_INV_EN
               work_d[127-32*(int'(cnt_q)+g) -: 32] = inv_q ? mix_inv(col) : mix_fwd(col);
`else
               work_d[127-32*(int'(cnt_q)+g) -: 32] = mix_fwd(col);
`endif
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_STEP;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
`ifdef MIXCOL_INV_EN
         inv_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef MIXCOL_INV_EN
         inv_q   <= inv_d;
`endif
      end
   end

   // Working register needs no reset: it is only visible through the DONE-gated output.
   always_ff @(posedge clk) begin
      work_q <= work_d;
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_state = out_valid ? work_q : '0;
`ifdef MIXCOL_INV_EN
   assign out_inv   = out_valid & inv_q;
`else
   assign out_inv   = 1'b0;
`endif

endmodule
